// File: rtl/spad_matls_resp.sv
// -----------------------------------------------------------------------------
// spad_matls_resp
//
// Scratchpad-side responder for matrix load/store requests from the matrix
// load/store functional unit. One request is accepted at a time. The matrix is
// walked row by row at base + r*stride:
//   - load  : each memory beat is written into the destination matrix register.
//   - store : each source row is read from the matrix register file and written
//             out to memory.
// Completion is reported with a single-cycle mhit pulse.
//
// Handshake semantics (all interfaces):
//   - A request is accepted on a rising edge where req_valid && req_ready.
//     req_valid seen while req_ready is low is ignored, not queued, so the FU
//     must hold the request until it is accepted.
//   - A memory beat (mem_ren or mem_wen) holds its address and data stable
//     until the rising edge where mem_ack is high; that edge retires the beat.
//     mem_ack is ignored whenever no beat is outstanding.
//
// Ports:
//   CLK, nRST             clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake from/to the FU
//   req_store             0 = load (mem -> mreg), 1 = store (mreg -> mem)
//   req_mreg              matrix register index
//   req_addr, req_stride  base byte address and two's complement row stride
//   mhit                  one-cycle completion pulse
//   mem_ren/mem_wen       memory read / write request for the current row
//   mem_addr, mem_wdata   row address and store data
//   mem_rdata, mem_ack    load data and beat completion from memory
//   mrf_sel, mrf_row      matrix register file row select
//   mrf_wen, mrf_wdata    matrix register file write (loads)
//   mrf_rdata             combinational matrix register file read (stores)
//   state_dbg             current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// ROWS must be at least 2.
// -----------------------------------------------------------------------------
module spad_matls_resp #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int MREG_W = 4,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  // request from the functional unit
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [MREG_W-1:0] req_mreg,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_stride,
  output logic              req_ready,
  output logic              mhit,
  // scratchpad memory
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // matrix register file
  output logic [MREG_W-1:0] mrf_sel,
  output logic [ROW_W-1:0]  mrf_row,
  output logic              mrf_wen,
  output logic [DATA_W-1:0] mrf_wdata,
  input  logic [DATA_W-1:0] mrf_rdata,
  // debug
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t              state;
  logic                store_q;
  logic [MREG_W-1:0]   mreg_q;
  logic [ADDR_W-1:0]   stride_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ROW_W-1:0]    row_q;
  logic                in_access;

  // ---------------------------------------------------------------------------
  // FSM. req_ready, mhit, mem_ren and mem_wen are registered alongside the
  // state so they are glitch-free at the clock edge. A reset in any state
  // simply drops everything: no partial completion is ever reported.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mhit      <= 1'b0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      store_q   <= 1'b0;
      mreg_q    <= '0;
      stride_q  <= '0;
      addr_q    <= '0;
      row_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ACCESS;
            req_ready <= 1'b0;
            mem_ren   <= !req_store;
            mem_wen   <= req_store;
            store_q   <= req_store;
            mreg_q    <= req_mreg;
            stride_q  <= req_stride;
            addr_q    <= req_addr;
            row_q     <= '0;
          end
        end

        ACCESS: begin
          if (mem_ack) begin
            if (row_q == LAST_ROW) begin
              state   <= DONE;
              mem_ren <= 1'b0;
              mem_wen <= 1'b0;
              mhit    <= 1'b1;
            end else begin
              row_q  <= row_q + ROW_W'(1);
              // Modulo 2^ADDR_W: negative strides and wrap-around fall out of
              // plain two's complement addition.
              addr_q <= addr_q + stride_q;
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          mhit      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mhit      <= 1'b0;
          mem_ren   <= 1'b0;
          mem_wen   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath outputs are decoded from the state so they read as zero outside
  // ACCESS (including immediately on reset). The register-file write and the
  // store data follow the combinational inputs in the ack cycle.
  // ---------------------------------------------------------------------------
  assign in_access = (state == ACCESS);

  assign mem_addr  = in_access ? addr_q : '0;
  assign mrf_sel   = in_access ? mreg_q : '0;
  assign mrf_row   = in_access ? row_q  : '0;
  assign mem_wdata = (in_access && store_q) ? mrf_rdata : '0;

  // mem_rdata only matters on loads; stores never write the register file.
  assign mrf_wen   = in_access && !store_q && mem_ack;
  assign mrf_wdata = mrf_wen ? mem_rdata : '0;

  assign state_dbg = state;

endmodule

// File: doc/spad_matls_resp.md
# spad_matls_resp

Scratchpad-side responder for matrix load/store requests issued by the matrix load/store functional unit. It accepts one request at a time and walks the matrix row by row at `base + r*stride`. For a load it moves each memory row into the destination matrix register; for a store it moves each source row out to memory. It signals completion back to the functional unit with a one-cycle `mhit` pulse.

## Interface
Parameters:
- ROWS, 4, rows per matrix register (one memory beat per row)
- DATA_W, 64, bits per row (4 x 16-bit elements)
- ADDR_W, 32, byte address / stride width (word_t)
- MREG_W, 4, matrix register index width (matbits_t)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous, active-low reset
- req_valid  in  1  request present from FU
- req_store  in  1  0 = load (mem -> mreg), 1 = store (mreg -> mem)
- req_mreg  in  MREG_W  matrix register (rd for load, source for store)
- req_addr  in  ADDR_W  base address (rs + imm, computed by FU)
- req_stride  in  ADDR_W  byte stride between rows, two's complement
- req_ready  out  1  high when idle and able to accept
- mhit  out  1  one-cycle completion pulse to FU
- mem_ren  out  1  memory read request
- mem_wen  out  1  memory write request
- mem_addr  out  ADDR_W  row address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  memory completes the current beat this cycle
- mrf_sel  out  MREG_W  matrix register selected
- mrf_row  out  $clog2(ROWS)  row selected
- mrf_wen  out  1  write mem_rdata into mrf_sel/mrf_row
- mrf_wdata  out  DATA_W  load write data (= mem_rdata)
- mrf_rdata  in  DATA_W  combinational read of mrf_sel/mrf_row (stores)

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch store, mreg and stride; set addr=req_addr, row=0; go to ACCESS.
- ACCESS:
  - mem_ren=!store, mem_wen=store; mem_addr=addr; mrf_sel=mreg; mrf_row=row.
  - Store: mem_wdata=mrf_rdata.
  - Request and address are held stable until mem_ack.
- On mem_ack in ACCESS:
  - Load: mrf_wen=1 with mrf_wdata=mem_rdata in the same cycle.
  - If row==ROWS-1, go to DONE.
  - Otherwise row+=1 and addr+=stride.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent. Negative stride is handled by two's complement addition. Stride 0 is legal and hits the same address every row.
- DONE: mhit=1 for exactly this cycle, then go to IDLE.
- req_valid outside IDLE is ignored (not queued); the FU must hold the request until it sees req_ready.
- mem_ack outside ACCESS is ignored.
- mem_rdata is ignored on stores.
- Reset (any state, including mid-transfer):
  - Abort and go to IDLE.
  - req_ready=1; all other outputs 0 (mhit, mem_ren, mem_wen, mrf_wen, mem_addr, mem_wdata, mrf_sel, mrf_row, mrf_wdata).
  - No partial completion is reported.

## Timing
- Accept in cycle T (req_valid & req_ready); ACCESS begins at T+1.
- With zero-wait memory (mem_ack every cycle), rows complete at T+1..T+ROWS, mhit pulses at T+ROWS+1, and req_ready is high at T+ROWS+2.
- Each wait cycle (mem_ack=0) adds one cycle.
- Back-to-back requests have a minimum spacing of ROWS+2 cycles.
- Outputs in ACCESS and DONE are state-decoded and glitch-free at the clock edge.
- mrf_rdata is sampled combinationally in the ack cycle.

## Test plan
- Reset values: nRST low -> req_ready=1 and every other output 0; no mhit while held in reset.
- Load, zero-wait: base 0x1000, stride 0x40, mreg 3, mem_ack tied 1 -> mem_addr sequence 0x1000, 0x1040, 0x1080, 0x10C0; mrf_wen rows 0..3 carry mem_rdata; mhit at T+5; req_ready at T+6.
- Store with waits: base 0x2000, stride 8, mem_ack every other cycle -> mem_wen held with stable address until each ack; mem_wdata equals mrf_rdata for rows 0..3; mhit after the 4th ack plus 1 cycle.
- Stride edge cases:
  - Stride 0 -> all four addresses 0x3000.
  - Base 0xFFFFFFF0 with stride 0x10 -> 0xFFFFFFF0, 0x00000000, 0x10, 0x20.
  - Stride -0x40 from 0x100 -> 0x100, 0xC0, 0x80, 0x40.
- Busy request: second req_valid during ACCESS with different fields -> ignored; first transfer completes unaltered; second is accepted only once req_ready returns.
- Reset mid-transfer: nRST asserted after row 1 ack -> immediate IDLE outputs, no mhit; a new load after release starts at row 0 of its own base address.
